// File: rtl/lsu.sv
// Load/store unit: checks and formats datapath loads/stores, runs a req/ack
// transaction with a word-organised RAM and reports misalign/fault events.
module lsu #(
  parameter int MEM_AW  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [2:0]        f3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic              fault,
  output logic [31:0]       bad_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;
  localparam logic [7:0] TO_INIT  = 8'(TIMEOUT);

  logic [1:0]        state_r;
  logic              we_r;
  logic [2:0]        f3_r;
  logic [1:0]        off_r;
  logic [MEM_AW-3:0] mem_addr_r;
  logic [3:0]        mem_be_r;
  logic [31:0]       mem_wdata_r;
  logic [7:0]        cnt_r;
  logic              err_mis_r;
  logic [31:0]       rdata_r;
  logic [31:0]       bad_addr_r;

  logic              f3_ok_s;
  logic              align_ok_s;
  logic              range_ok_s;
  logic [3:0]        be_s;
  logic [31:0]       wd_s;

  // Select and sign/zero-extend the addressed lane of a RAM word.
  function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f)
      3'd0:    extract = {{24{b[7]}}, b};
      3'd1:    extract = {{16{h[15]}}, h};
      3'd4:    extract = {24'd0, b};
      3'd5:    extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  // Request legality, alignment, range, byte-enable and store-lane formatting.
  always_comb begin
    f3_ok_s    = 1'b0;
    align_ok_s = 1'b1;
    be_s       = 4'b1111;
    wd_s       = 32'd0;
    case (f3)
      3'd0, 3'd1, 3'd2: f3_ok_s = 1'b1;
      3'd4, 3'd5:       f3_ok_s = ~we;
      default:          f3_ok_s = 1'b0;
    endcase
    case (f3[1:0])
      2'd1:    align_ok_s = ~addr[0];
      2'd2:    align_ok_s = (addr[1:0] == 2'b00);
      default: align_ok_s = 1'b1;
    endcase
    range_ok_s = (addr[31:MEM_AW] == {(32-MEM_AW){1'b0}});
    case (f3[1:0])
      2'd0:    be_s = 4'b0001 << addr[1:0];
      2'd1:    be_s = addr[1] ? 4'b1100 : 4'b0011;
      default: be_s = 4'b1111;
    endcase
    if (we) begin
      case (f3[1:0])
        2'd0:    wd_s = {4{wdata[7:0]}};
        2'd1:    wd_s = {2{wdata[15:0]}};
        default: wd_s = wdata;
      endcase
    end else begin
      wd_s = 32'd0;
    end
  end

  // Transaction FSM with latched request, timeout counter and load capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      we_r        <= 1'b0;
      f3_r        <= 3'd0;
      off_r       <= 2'd0;
      mem_addr_r  <= '0;
      mem_be_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
      cnt_r       <= 8'd0;
      err_mis_r   <= 1'b0;
      rdata_r     <= 32'd0;
      bad_addr_r  <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (!f3_ok_s || !align_ok_s) begin
              bad_addr_r <= addr;
              err_mis_r  <= 1'b1;
              state_r    <= S_ERR;
            end else if (!range_ok_s) begin
              bad_addr_r <= addr;
              err_mis_r  <= 1'b0;
              state_r    <= S_ERR;
            end else begin
              we_r        <= we;
              f3_r        <= f3;
              off_r       <= addr[1:0];
              mem_addr_r  <= addr[MEM_AW-1:2];
              mem_be_r    <= be_s;
              mem_wdata_r <= wd_s;
              cnt_r       <= TO_INIT;
              state_r     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            if (!we_r) begin
              rdata_r <= extract(f3_r, off_r, mem_rdata);
            end
            cnt_r   <= 8'd0;
            state_r <= S_DONE;
          end else if (cnt_r <= 8'd1) begin
            // In-range accesses only reach the bus, so the upper address bits are zero.
            bad_addr_r <= {{(32-MEM_AW){1'b0}}, mem_addr_r, off_r};
            err_mis_r  <= 1'b0;
            cnt_r      <= 8'd0;
            state_r    <= S_ERR;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        S_DONE:  state_r <= S_IDLE;
        S_ERR:   state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign stall     = start & ((state_r == S_IDLE) | (state_r == S_ACCESS));
  assign done      = (state_r == S_DONE);
  assign misalign  = (state_r == S_ERR) & err_mis_r;
  assign fault     = (state_r == S_ERR) & ~err_mis_r;
  assign mem_req   = (state_r == S_ACCESS);
  assign mem_we    = (state_r == S_ACCESS) & we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;
  assign bad_addr  = bad_addr_r;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu (MEM_AW=16, TIMEOUT=3).
module tb_lsu;
  logic        clk, rst, start, we, mem_ack;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, bad_addr, mem_wdata;
  logic        stall, done, misalign, fault, mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  // observations recorded by run_access
  logic        o_stall0, o_stall1, o_stall2, o_req1, o_we1, o_mis1, o_fault1, o_done2, o_req_any;
  logic [13:0] o_addr1;
  logic [3:0]  o_be1;
  logic [31:0] o_wd1, o_rdata2, o_bad1;

  lsu #(.MEM_AW(16), .TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .f3(f3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .done(done), .misalign(misalign), .fault(fault),
    .bad_addr(bad_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one access with ack offered in cycle 1; record what the DUT shows.
  task automatic run_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] word);
    @(negedge clk);
    start = 1'b1; we = w; f3 = f; addr = a; wdata = wd;
    #1 o_stall0 = stall;
    o_req_any = mem_req;
    @(negedge clk);
    o_req1 = mem_req; o_we1 = mem_we; o_addr1 = mem_addr; o_be1 = mem_be; o_wd1 = mem_wdata;
    o_stall1 = stall; o_mis1 = misalign; o_fault1 = fault; o_bad1 = bad_addr;
    o_req_any = o_req_any | mem_req;
    mem_ack = 1'b1; mem_rdata = word;
    @(negedge clk);
    o_done2 = done; o_rdata2 = rdata; o_stall2 = stall;
    o_req_any = o_req_any | mem_req;
    mem_ack = 1'b0; start = 1'b0;
    @(negedge clk);
    o_req_any = o_req_any | mem_req;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    #1;
    checks++; if ({done, misalign, fault, mem_req, mem_we, stall} !== 6'd0) begin failures++; $display("FAIL reset_ctl got %b exp 000000", {done, misalign, fault, mem_req, mem_we, stall}); end
    checks++; if ({rdata, bad_addr, mem_wdata} !== 96'd0) begin failures++; $display("FAIL reset_data got %h exp 0", {rdata, bad_addr, mem_wdata}); end
    checks++; if ({mem_addr, mem_be} !== 18'd0) begin failures++; $display("FAIL reset_bus got %h exp 0", {mem_addr, mem_be}); end
    @(negedge clk); rst = 1'b0;
    start = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_idle got %b exp 1", stall); end
    start = 1'b0; #1;
  endtask

  task automatic test_lw();
    run_access(1'b0, 3'd2, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF);
    checks++; if ({o_req1, o_we1, o_addr1, o_be1} !== {1'b1, 1'b0, 14'd4, 4'b1111}) begin failures++; $display("FAIL lw_bus got %b %b %h %b exp 1 0 0004 1111", o_req1, o_we1, o_addr1, o_be1); end
    checks++; if ({o_stall0, o_stall1, o_stall2} !== 3'b110) begin failures++; $display("FAIL lw_stall got %b exp 110", {o_stall0, o_stall1, o_stall2}); end
    checks++; if (o_done2 !== 1'b1) begin failures++; $display("FAIL lw_done got %b exp 1", o_done2); end
    checks++; if (o_rdata2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_rdata got %h exp deadbeef", o_rdata2); end
  endtask

  task automatic test_sub_loads();
    run_access(1'b0, 3'd0, 32'h3, 32'd0, 32'h80F1_7F02);
    checks++; if (o_rdata2 !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got %h exp ffffff80", o_rdata2); end
    checks++; if (o_be1 !== 4'b1000) begin failures++; $display("FAIL lb_be got %b exp 1000", o_be1); end
    run_access(1'b0, 3'd4, 32'h3, 32'd0, 32'h80F1_7F02);
    checks++; if (o_rdata2 !== 32'h0000_0080) begin failures++; $display("FAIL lbu got %h exp 00000080", o_rdata2); end
    run_access(1'b0, 3'd1, 32'h2, 32'd0, 32'h80F1_7F02);
    checks++; if (o_rdata2 !== 32'hFFFF_80F1) begin failures++; $display("FAIL lh got %h exp ffff80f1", o_rdata2); end
    checks++; if (o_be1 !== 4'b1100) begin failures++; $display("FAIL lh_be got %b exp 1100", o_be1); end
    run_access(1'b0, 3'd5, 32'h0, 32'd0, 32'h80F1_7F02);
    checks++; if (o_rdata2 !== 32'h0000_7F02) begin failures++; $display("FAIL lhu got %h exp 00007f02", o_rdata2); end
  endtask

  task automatic test_store();
    run_access(1'b1, 3'd0, 32'h6, 32'h1234_56AB, 32'h5555_5555);
    checks++; if ({o_we1, o_addr1, o_be1} !== {1'b1, 14'd1, 4'b0100}) begin failures++; $display("FAIL sb_bus got %b %h %b exp 1 0001 0100", o_we1, o_addr1, o_be1); end
    checks++; if (o_wd1 !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got %h exp abababab", o_wd1); end
    checks++; if ({o_done2, o_rdata2} !== {1'b1, 32'h0000_7F02}) begin failures++; $display("FAIL sb_done_rdata got %b %h exp 1 00007f02", o_done2, o_rdata2); end
    run_access(1'b1, 3'd1, 32'h2, 32'h1234_56AB, 32'h0);
    checks++; if ({o_be1, o_wd1} !== {4'b1100, 32'h56AB_56AB}) begin failures++; $display("FAIL sh_bus got %b %h exp 1100 56ab56ab", o_be1, o_wd1); end
  endtask

  task automatic test_misalign();
    run_access(1'b1, 3'd1, 32'h5, 32'h0, 32'h0);
    checks++; if ({o_mis1, o_fault1, o_req_any, o_done2} !== 4'b1000) begin failures++; $display("FAIL sh_mis got %b exp 1000", {o_mis1, o_fault1, o_req_any, o_done2}); end
    checks++; if (o_bad1 !== 32'h5) begin failures++; $display("FAIL sh_mis_bad got %h exp 00000005", o_bad1); end
    run_access(1'b0, 3'd3, 32'h8, 32'h0, 32'h0);
    checks++; if ({o_mis1, o_fault1, o_req_any, o_bad1} !== {3'b100, 32'h8}) begin failures++; $display("FAIL f3_ill got %b %h exp 100 00000008", {o_mis1, o_fault1, o_req_any}, o_bad1); end
    run_access(1'b1, 3'd4, 32'h8, 32'h0, 32'h0);
    checks++; if ({o_mis1, o_req_any} !== 2'b10) begin failures++; $display("FAIL st_f3_ill got %b exp 10", {o_mis1, o_req_any}); end
    checks++; if (rdata !== 32'h0000_7F02) begin failures++; $display("FAIL err_rdata got %h exp 00007f02", rdata); end
  endtask

  task automatic test_range();
    run_access(1'b0, 3'd2, 32'h0001_0000, 32'h0, 32'h0);
    checks++; if ({o_mis1, o_fault1, o_req_any, o_done2} !== 4'b0100) begin failures++; $display("FAIL range got %b exp 0100", {o_mis1, o_fault1, o_req_any, o_done2}); end
    checks++; if (o_bad1 !== 32'h0001_0000) begin failures++; $display("FAIL range_bad got %h exp 00010000", o_bad1); end
  endtask

  task automatic test_timeout();
    int fcyc;
    logic req_gap;
    fcyc = 0; req_gap = 1'b0;
    @(negedge clk);
    start = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h20;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (fault) begin fcyc = c; break; end
      if (!mem_req) req_gap = 1'b1;
    end
    checks++; if (fcyc != 4) begin failures++; $display("FAIL timeout_cycle got %0d exp 4", fcyc); end
    checks++; if ({req_gap, mem_req, misalign, bad_addr} !== {3'b000, 32'h20}) begin failures++; $display("FAIL timeout_state got %b %h exp 000 00000020", {req_gap, mem_req, misalign}, bad_addr); end
    start = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req, fault, done} !== 3'b000) begin failures++; $display("FAIL timeout_after got %b exp 000", {mem_req, fault, done}); end
  endtask

  task automatic test_rst_mid();
    logic seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h40;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got %b exp 1", mem_req); end
    rst = 1'b1; start = 1'b0; #1;
    checks++; if ({mem_req, done, fault, rdata} !== {3'b000, 32'd0}) begin failures++; $display("FAIL rst_mid got %b %h exp 000 0", {mem_req, done, fault}, rdata); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen_done = seen_done | done | fault;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL rst_mid_pulse got %b exp 0", seen_done); end
    run_access(1'b0, 3'd2, 32'h4, 32'h0, 32'h1122_3344);
    checks++; if ({o_done2, o_rdata2, o_addr1} !== {1'b1, 32'h1122_3344, 14'd1}) begin failures++; $display("FAIL rst_after_lw got %b %h %h exp 1 11223344 0001", o_done2, o_rdata2, o_addr1); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h10;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 1'b0; addr = 32'h14;
    checks++; if ({done, rdata} !== {1'b1, 32'h0BAD_F00D}) begin failures++; $display("FAIL b2b_first got %b %h exp 1 0badf00d", done, rdata); end
    @(negedge clk);
    checks++; if ({stall, mem_req} !== 2'b10) begin failures++; $display("FAIL b2b_idle got %b exp 10", {stall, mem_req}); end
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 14'd5}) begin failures++; $display("FAIL b2b_req got %b %h exp 1 0005", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0; start = 1'b0;
    checks++; if ({done, rdata} !== {1'b1, 32'hCAFE_F00D}) begin failures++; $display("FAIL b2b_second got %b %h exp 1 cafef00d", done, rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub_loads();
    test_store();
    test_misalign();
    test_range();
    test_timeout();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the datapath and the data RAM. Takes the datapath's effective address (`aluRes`), store data (`writeData`) and `funct3`, and runs a req/ack transaction with a word-organised RAM. It returns sign/zero-extended load data on the datapath's `readData` input and stalls the core while the transaction is outstanding. It also detects misaligned, illegal and out-of-range accesses and bus timeouts, and reports them to the CSR/exception logic.

## Interface
Parameters:
- `MEM_AW`, 16: byte-address width of the data RAM. Word address is `MEM_AW-2` bits.
- `TIMEOUT`, 15: maximum number of cycles to wait for `mem_ack`. Range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: current instruction is a load or store. Held by the core until `done`, `misalign` or `fault`.
- `we` in 1: 1 = store, 0 = load.
- `f3` in 3: `funct3` of the instruction.
- `addr` in 32: effective byte address (`aluRes`).
- `wdata` in 32: store data (`writeData`).
- `rdata` out 32: extended load data, fed to the datapath `readData`.
- `stall` out 1: combinational, freezes PC/register write.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: one-cycle pulse; misaligned or illegal `f3`.
- `fault` out 1: one-cycle pulse; out-of-range address or ack timeout.
- `bad_addr` out 32: `addr` of the last access that raised `misalign` or `fault`.
- `mem_req` out 1: bus request, held until ack.
- `mem_we` out 1: bus write enable.
- `mem_addr` out MEM_AW-2: word address.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: RAM read word, valid in the `mem_ack` cycle.
- `mem_ack` in 1: RAM completion.

## Operation
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE: a request is accepted on the edge where `start=1`.
  - `f3` and alignment are checked first.
  - If the check passes and the address is in range, latch `we`, `f3`, `addr[1:0]`, `mem_addr`, `mem_be` and `mem_wdata`, then go to ACCESS.
  - Otherwise latch `bad_addr` and go to ERR.
- Legal `f3` for loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Legal `f3` for stores: 0 SB, 1 SH, 2 SW. Any other value raises `misalign`.
- Misalign conditions:
  - Halfword access with `addr[0]=1`.
  - Word access with `addr[1:0]!=0`.
- Out of range: any `addr[31:MEM_AW]` bit set. Raises `fault` and issues no bus request.
- Byte enables:
  - Byte: `mem_be = 1<<addr[1:0]`.
  - Half: `addr[1]` ? 1100 : 0011.
  - Word: 1111.
- Store data: byte stores replicate `wdata[7:0]` ×4; half stores replicate `wdata[15:0]` ×2. For loads, `mem_be` = the same mask and `mem_wdata` = 0.
- ACCESS:
  - `mem_req=1`; `mem_we` = latched `we`.
  - A down-counter is loaded with `TIMEOUT` on entry and decrements each cycle without ack.
  - `mem_ack=1`: on a load, capture the extracted and extended lane into `rdata`; go to DONE.
  - Counter reaches 0 without ack: drop `mem_req`, latch `bad_addr`, go to ERR with `fault`.
- Load extraction:
  - Byte lane `addr[1:0]`, half lane `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- DONE: `done=1` for one cycle, then IDLE. `start` is ignored in DONE.
- ERR: exactly one of `misalign`/`fault` is 1 for one cycle, then IDLE. `start` is ignored in ERR.
- `stall = start & (state==IDLE | state==ACCESS)`.
- `rdata` holds its value until the next successful load. Stores and errors do not change it.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset values: state IDLE; `rdata` 0, `bad_addr` 0; `stall` follows `start` (IDLE). All other outputs are 0.
- `rst` asserted mid-ACCESS: `mem_req` drops asynchronously, the counter clears, and no `done` or `fault` is issued.
- Load/store latency with `start` accepted at edge 0:
  - `mem_req` high in cycle 1.
  - Ack in cycle k (k≥1) gives `done` in cycle k+1, with `rdata` valid from cycle k+1.
  - Minimum 2 cycles of stall.
- Error latency: `misalign`/`fault` (pre-bus check) in cycle 1. A timeout fault occurs in cycle `TIMEOUT+1`.
- Back-to-back: with `start` still high after DONE, a new acceptance happens in the following IDLE cycle.

## Test plan
- LW at `0x0000_0010`, RAM returns `0xDEAD_BEEF` with ack in cycle 1:
  - Bus signals: `mem_addr=4`, `mem_be=1111`.
  - `done` in cycle 2, `rdata=0xDEADBEEF`, `stall` high for cycles 0–1.
- Byte/half loads of word `0x80F1_7F02`:
  - LB at addr 3 → `0xFFFF_FF80`; LBU at addr 3 → `0x0000_0080`.
  - LH at addr 2 → `0xFFFF_80F1`; LHU at addr 0 → `0x0000_7F02`.
- SB at addr 6, `wdata=0x1234_56AB` → `mem_be=0100`, `mem_wdata=0xABABABAB`, `mem_we=1`, `rdata` unchanged.
- SH at addr `0x5`:
  - `misalign` in cycle 1, `bad_addr=0x5`, `mem_req` never asserted.
  - Load with `f3=3` gives the same response.
- Address `0x0001_0000` with `MEM_AW=16` → `fault` in cycle 1. Ack withheld with `TIMEOUT=3` → `fault` in cycle 4 and `mem_req` low afterwards.
- `rst` pulsed during ACCESS → `mem_req` low immediately, state IDLE, no `done`. A following LW completes normally.
